// File: rtl/instr_pkg.sv
// Shared encodings and types for the random RV32I instruction stream generator.
// Opcodes, funct3 values, LFSR taps and the stream mode enum.
package instr_pkg;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      MODE_R,
      MODE_I,
      MODE_RI,
      MODE_ALL
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GEN,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      K_R,
      K_I,
      K_LW,
      K_SW
   } kind_e;

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step enable.
// Load has priority over enable.
module lfsr32_galois
   import instr_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        enable,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   logic [31:0] r_state;
   logic [31:0] w_step;

   assign w_step = (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 32'h0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= RESET_VAL;
      end else if (load) begin
         r_state <= seed;
      end else if (enable) begin
         r_state <= w_step;
      end
   end

   assign state = r_state;

endmodule

// File: rtl/instr_stream_gen.sv
// Streams pseudo-random RV32I instructions out and into instruction memory.
// Instruction k is decoded combinationally from LFSR state S_k.
module instr_stream_gen
   import instr_pkg::*;
#(
   parameter int          DEPTH      = 256,
   parameter logic [31:0] SEED       = 32'h0000_0001,
   parameter logic [4:0]  REG_MASK   = 5'b11111,
   parameter int          DMEM_BYTES = 1024,
   parameter bit          NO_X0_RD   = 1'b1,
   localparam int         CW = $clog2(DEPTH + 1),
   localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] count,
   input  logic [1:0]    mode,
   input  logic [31:0]   seed_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          busy,
   output logic          done
);

   state_e        r_state;
   state_e        w_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_idx;
   mode_e         r_mode;

   logic          w_start;
   logic          w_fire;
   logic          w_last;
   logic [CW-1:0] w_cnt_in;
   logic [31:0]   w_seed;
   logic [31:0]   w_s;

   logic [4:0]    w_rd0;
   logic [4:0]    w_rd;
   logic [4:0]    w_rs1;
   logic [4:0]    w_rs2;
   logic [2:0]    w_f3;
   logic [6:0]    w_f7;
   logic [11:0]   w_imm;
   logic [11:0]   w_off;
   kind_e         w_kind;
   logic [31:0]   w_instr;
   logic          w_unused;

   assign w_start  = start && (r_state == ST_IDLE);
   assign w_cnt_in = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
   assign w_seed   = (seed_in == 32'h0) ? SEED : seed_in;
   assign w_fire   = out_valid && out_ready;
   assign w_last   = (r_idx + CW'(1)) == r_cnt;

   lfsr32_galois #(
      .RESET_VAL (SEED)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .load   (w_start),
      .enable (w_fire),
      .seed   (w_seed),
      .state  (w_s)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_idx  <= '0;
         r_mode <= MODE_R;
      end else if (w_start) begin
         r_cnt  <= w_cnt_in;
         r_idx  <= '0;
         r_mode <= mode_e'(mode);
      end else if (w_fire) begin
         r_idx <= r_idx + CW'(1);
      end else if (r_state == ST_DONE) begin
         r_idx <= '0;
      end
   end

   always_comb begin
      w_next    = r_state;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (w_cnt_in == '0) ? ST_DONE : ST_GEN;
            end
         end
         ST_GEN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (w_fire && w_last) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Register fields are masked first; the x0 override on rd goes last.
   assign w_rd0 = w_s[11:7] & REG_MASK;
   assign w_rd  = (NO_X0_RD && (w_rd0 == 5'd0)) ? 5'd1 : w_rd0;
   assign w_rs1 = w_s[19:15] & REG_MASK;
   assign w_rs2 = w_s[24:20] & REG_MASK;
   assign w_f3  = w_s[14:12];
   assign w_f7  = {1'b0, w_s[30], 5'b0};
   assign w_off = w_s[31:20] & 12'(DMEM_BYTES - 4);

   always_comb begin
      w_kind = K_R;
      unique case (r_mode)
         MODE_R:   w_kind = K_R;
         MODE_I:   w_kind = K_I;
         MODE_RI:  w_kind = w_s[0] ? K_I : K_R;
         MODE_ALL: w_kind = kind_e'(w_s[1:0]);
      endcase
   end

   always_comb begin
      w_imm   = w_s[31:20];
      w_instr = '0;
      if (w_f3 == F3_SLL) begin
         w_imm[11:5] = 7'b0;
      end else if (w_f3 == F3_SR) begin
         w_imm[11:5] = w_f7;
      end
      unique case (w_kind)
         K_R: begin
            w_instr = {
               ((w_f3 == F3_ADD) || (w_f3 == F3_SR)) ? w_f7 : 7'b0,
               w_rs2, w_rs1, w_f3, w_rd, OP_R
            };
         end
         K_I: begin
            w_instr = {w_imm, w_rs1, w_f3, w_rd, OP_I};
         end
         K_LW: begin
            w_instr = {w_off, 5'd0, F3_W, w_rd, OP_LW};
         end
         K_SW: begin
            w_instr = {
               w_off[11:5], w_rs2, 5'd0, F3_W, w_off[4:0], OP_SW
            };
         end
      endcase
   end

   // Low LFSR bits only feed the type select.
   assign w_unused = ^w_s[6:2];

   assign out_instr  = (r_state == ST_GEN) ? w_instr : 32'h0;
   assign imem_we    = w_fire;
   assign imem_addr  = r_idx[AW-1:0];
   assign imem_wdata = out_instr;

endmodule

// File: tb/tb_instr_stream_gen.sv
// Scoreboard bench for instr_stream_gen with an independent LFSR/decode model.
// Expected stream is queued at start and popped on every IMEM write.
module tb_instr_stream_gen;

   logic        clk;
   logic        reset;
   logic        start;
   logic [8:0]  count;
   logic [1:0]  mode;
   logic [31:0] seed_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        done;

   int n_checks;
   int n_errors;
   logic [39:0] sb[$];
   logic [1:0]  cur_mode;
   bit          seed1_run;

   instr_stream_gen dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .count      (count),
      .mode       (mode),
      .seed_in    (seed_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] step(input logic [31:0] s);
      logic [31:0] sh;
      sh = {1'b0, s[31:1]};
      return s[0] ? (sh ^ 32'h8020_0003) : sh;
   endfunction

   function automatic logic [31:0] model_instr(input logic [31:0] s,
                                               input logic [1:0] m);
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  hi;
      logic [11:0] imm;
      logic [11:0] off;
      logic [1:0]  k;
      rd  = s[11:7];
      if (rd == 5'd0) rd = 5'd1;
      f3  = s[14:12];
      hi  = s[30] ? 7'h20 : 7'h00;
      off = {2'b00, s[29:22], 2'b00};
      case (m)
         2'd0:    k = 2'd0;
         2'd1:    k = 2'd1;
         2'd2:    k = s[0] ? 2'd1 : 2'd0;
         default: k = s[1:0];
      endcase
      case (k)
         2'd0: begin
            return {(f3 == 3'd0 || f3 == 3'd5) ? hi : 7'h00,
                    s[24:20], s[19:15], f3, rd, 7'h33};
         end
         2'd1: begin
            imm = s[31:20];
            if (f3 == 3'd1) imm = {7'h00, s[24:20]};
            if (f3 == 3'd5) imm = {hi, s[24:20]};
            return {imm, s[19:15], f3, rd, 7'h13};
         end
         2'd2: return {off, 5'd0, 3'd2, rd, 7'h03};
         default: begin
            return {off[11:5], s[24:20], 5'd0, 3'd2, off[4:0], 7'h23};
         end
      endcase
   endfunction

   // Scoreboard pop and per-instruction property checks
   always @(negedge clk) begin
      logic [39:0] e;
      logic [11:0] off;
      if (reset && imem_we) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            check("imem_addr", imem_addr, e[39:32]);
            check("imem_wdata", imem_wdata, e[31:0]);
         end
         if (seed1_run && imem_addr == 8'd1)
            check("s1_instr", imem_wdata,
                  model_instr(32'h8020_0003, cur_mode));
         if (cur_mode == 2'd0) begin
            check("r_opcode", imem_wdata[6:0], 7'h33);
            check("r_funct7",
                  imem_wdata[31:25] == 7'h00 || imem_wdata[31:25] == 7'h20,
                  1);
         end
         if (cur_mode == 2'd3) begin
            if (imem_wdata[6:0] == 7'h03 || imem_wdata[6:0] == 7'h23) begin
               if (imem_wdata[6:0] == 7'h03) off = imem_wdata[31:20];
               else off = {imem_wdata[31:25], imem_wdata[11:7]};
               check("mem_rs1", imem_wdata[19:15], 5'd0);
               check("mem_align", off[1:0], 2'd0);
               check("mem_range", off < 12'd1024, 1);
            end
            if (imem_wdata[6:0] != 7'h23)
               check("rd_nonzero", imem_wdata[11:7] != 5'd0, 1);
         end
      end
   end

   task automatic check_idle_zero(input string p);
      check({p, "_valid"}, out_valid, 0);
      check({p, "_we"}, imem_we, 0);
      check({p, "_busy"}, busy, 0);
      check({p, "_done"}, done, 0);
      check({p, "_instr"}, out_instr, 0);
      check({p, "_addr"}, imem_addr, 0);
   endtask

   task automatic run(input int cnt, input logic [1:0] m,
                      input logic [31:0] sd, input int stall_idx,
                      input int abort_idx, input int ign_idx);
      logic [31:0] s;
      logic [31:0] held;
      int n, nf, last, cdone, stall_left;
      bit seen;
      s = (sd == 32'h0) ? 32'h1 : sd;
      n = (cnt > 256) ? 256 : cnt;
      seed1_run = (s == 32'h1);
      cur_mode = m;
      for (int k = 0; k < n; k++) begin
         sb.push_back({8'(k), model_instr(s, m)});
         s = step(s);
      end
      @(posedge clk); #1;
      count = 9'(cnt); mode = m; seed_in = sd;
      out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0; nf = 0; last = -1; cdone = -1;
      stall_left = 5; held = '0;
      for (int c = 0; c < 300; c++) begin
         if (abort_idx >= 0 && out_valid && imem_addr == 8'(abort_idx)) begin
            reset = 1'b0;
            @(posedge clk); #1;
            check_idle_zero("abort");
            reset = 1'b1;
            sb.delete();
            return;
         end
         if (ign_idx >= 0 && out_valid && imem_addr == 8'(ign_idx)) begin
            count = 9'd2; mode = 2'd3; seed_in = 32'h5;
            start = 1'b1;
         end
         out_ready = 1'b1;
         if (stall_idx >= 0 && out_valid &&
             imem_addr == 8'(stall_idx) && stall_left > 0) begin
            out_ready = 1'b0;
            if (stall_left == 5) held = out_instr;
            stall_left--;
         end
         @(negedge clk);
         if (!out_ready) begin
            check("stall_we", imem_we, 0);
            check("stall_instr", out_instr, held);
            check("stall_addr", imem_addr, 8'(stall_idx));
         end
         if (imem_we) begin
            nf++;
            last = c;
         end
         if (done) begin
            cdone = c;
            seen = 1;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("done_seen", seen, 1);
      check("fire_count", nf, n);
      if (n > 0) check("done_latency", cdone - last, 1);
      else check("done_latency0", cdone, 0);
      check("sb_leftover", sb.size(), 0);
      sb.delete();
      // start during the DONE cycle must not relaunch
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_pulse", done, 0);
      check("start_in_done_busy", busy, 0);
      check("start_in_done_valid", out_valid, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0; start = 1'b0; count = '0; mode = '0;
      seed_in = '0; out_ready = 1'b0;
      cur_mode = '0; seed1_run = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset");
      reset = 1'b1;

      run(16, 2'd0, 32'h1, -1, -1, 3);
      run(0, 2'd1, 32'h7, -1, -1, -1);
      run(10, 2'd1, 32'h0, -1, -1, -1);
      run(20, 2'd2, 32'hDEAD_BEEF, -1, -1, -1);
      run(40, 2'd3, 32'h0123_4567, 5, -1, -1);
      run(16, 2'd0, 32'h0000_ACE1, -1, 7, -1);
      run(16, 2'd0, 32'h0000_ACE1, -1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
